// File: rtl/mdu_ctrl_pkg.sv
// Shared md_op codes, FSM states and default latencies for the multiply/divide unit.
// MDU_MADD_EN widens the multiply class to the madd/msub family.
package mdu_ctrl_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_MADD) || (op == OP_MADDU) ||
           (op == OP_MSUB) || (op == OP_MSUBU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  // Ops that occupy the unit for a multi-cycle busy window.
  function automatic logic is_long_op(input logic [3:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for mult/div (and madd/msub under MDU_MADD_EN).
// Divide by zero and non-arithmetic ops return the current HI/LO unchanged.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] res_o
);

  logic [63:0] prod_s, prod_u;
  logic        rs_neg, rt_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  // Signed divide goes through magnitudes so INT_MIN / -1 wraps cleanly.
  always_comb begin
    prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    prod_u = {32'd0, rs_i} * {32'd0, rt_i};
    rs_neg = (op_i == OP_DIV) && rs_i[31];
    rt_neg = (op_i == OP_DIV) && rt_i[31];
    a_mag  = rs_neg ? (32'd0 - rs_i) : rs_i;
    b_mag  = rt_neg ? (32'd0 - rt_i) : rt_i;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = rs_neg ? (32'd0 - r_mag) : r_mag;

    res_o = {hi_i, lo_i};
    case (op_i)
      OP_MULT:  res_o = prod_s;
      OP_MULTU: res_o = prod_u;
      OP_DIV, OP_DIVU: begin
        if (rt_i != 32'd0) res_o = {rem, quo};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  res_o = {hi_i, lo_i} + prod_s;
      OP_MADDU: res_o = {hi_i, lo_i} + prod_u;
      OP_MSUB:  res_o = {hi_i, lo_i} - prod_s;
      OP_MSUBU: res_o = {hi_i, lo_i} - prod_u;
`endif
      default:  res_o = {hi_i, lo_i};
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage mult/div controller: owns HI/LO, runs a fixed busy window per op, stalls D-stage HI/LO users.
// Optional madd/msub family enabled by MDU_MADD_EN.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  input  logic        rd_hi,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] pend_q, pend_d;
  logic [63:0] arith_res;

  mdu_arith u_arith (
    .op_i  (md_op),
    .rs_i  (rs_val),
    .rt_i  (rt_val),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .res_o (arith_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  // Result is computed at issue against HI/LO as committed then; start during BUSY is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_long_op(md_op)) begin
            pend_d  = arith_res;
            cnt_d   = is_div_op(md_op) ? DIV_CNT : MULT_CNT;
            state_d = ST_BUSY;
          end else if (md_op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (md_op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          {hi_d, lo_d} = pend_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q == ST_BUSY);
  assign stall   = d_is_md && (busy || (start && is_long_op(md_op)));
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = rd_hi ? hi_q : lo_q;

endmodule
